micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter MEM_LATENCY, default 2: fixed memory latency in cycles; legal range 1..16.
REQ-002 Parameter HANDSHAKE, default 0: 0 = fixed-latency memory timing; 1 = memory cycles end on mem_ready.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk  input  1  clock; all state changes occur on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 opcode  input  7  opcode field of the instruction register; valid from ID onward.
REQ-007 alu_bcond  input  1  branch-taken result from the ALU; valid in EX1.
REQ-008 halt_cond  input  1  ECALL halt condition (x17 == 10); valid in ID.
REQ-009 mem_ready  input  1  memory completion; used only when HANDSHAKE=1.
REQ-010 current_state  output  3  registered state encoding.
REQ-011 ir_write, pc_write, mem_read, mem_write, reg_write  output  1 each  control strobes.
REQ-012 halted  output  1  high while in HALT.
REQ-013 retired  output  CNT_W  count of completed instructions.

Function
REQ-014 States SHALL be IF=0, ID=1, EX1=2, EX2=3, MEM=4, WB=5, HALT=6; encoding 7 SHALL return to IF on the next edge.
REQ-015 A memory cycle is "done" when HANDSHAKE=0 and wait_cnt == MEM_LATENCY-1, or when HANDSHAKE=1 and mem_ready=1.
REQ-016 wait_cnt SHALL clear on entry to IF or MEM and increment each cycle spent there while the cycle is not done.
REQ-017 IF: mem_read=1; when done, ir_write=1 and next=ID; otherwise remain in IF.
REQ-018 ID: ECALL with halt_cond=1 -> HALT; ECALL with halt_cond=0 -> IF with pc_write=1; all other opcodes -> EX1.
REQ-019 EX1: BRANCH with alu_bcond=0 -> IF with pc_write=1; otherwise -> EX2.
REQ-020 EX2: BRANCH -> IF with pc_write=1; ARITHMETIC, ARITHMETIC_IMM, JAL, JALR, LUI, AUIPC -> WB; LOAD, STORE -> MEM; any other opcode -> IF with pc_write=1.
REQ-021 MEM: mem_read=1 for LOAD and mem_write=1 for STORE, held for the entire memory cycle; when done, LOAD -> WB and STORE -> IF with pc_write=1.
REQ-022 WB: reg_write=1 and pc_write=1 for exactly one cycle; next=IF.
REQ-023 HALT: remains until reset; all strobes 0; halted=1.
REQ-024 Strobes SHALL be combinational from current_state, wait/done status and inputs; each strobe SHALL be 0 in every state not listed for it.
REQ-025 retired SHALL increment on every cycle with pc_write=1 and saturate at all-ones.
REQ-026 When HANDSHAKE=1, mem_ready outside IF/MEM SHALL be ignored; mem_ready=1 on the first IF cycle completes the fetch in one cycle.
REQ-027 When HANDSHAKE=0, mem_ready SHALL be ignored, and MEM_LATENCY=1 makes IF and MEM single-cycle.

Reset
REQ-028 When reset=1 at a rising edge: current_state=IF, wait_cnt=0, retired=0, halted=0; reset dominates every other event, including mid-MEM and HALT.
REQ-029 The first cycle after reset deassertion is IF with mem_read=1.

Structure
REQ-030 State encodings and opcode constants SHALL live in the shared state and opcode header files, not inside the module.
REQ-031 The latency/handshake wait counter SHALL be one sub-module, mem_wait_timer (inputs: start, ready; output: done).
REQ-032 Next-state logic and the state register SHALL reside in micro_sequencer.

Verification
REQ-033 HANDSHAKE=0, MEM_LATENCY=3, ARITHMETIC -> IF occupies 3 cycles with ir_write on the 3rd; then ID, EX1, EX2, WB; retired=1 after 7 cycles.
REQ-034 BRANCH with alu_bcond=0 -> IF, ID, EX1, IF with pc_write=1 in EX1; with alu_bcond=1, EX2 is visited and pc_write=1 in EX2.
REQ-035 HANDSHAKE=1, LOAD with mem_ready asserted on the 4th MEM cycle -> mem_read held for 4 MEM cycles, then WB with reg_write=1.
REQ-036 ECALL with halt_cond=1 -> HALT, halted=1, retired frozen for 20 cycles; reset pulse -> IF, retired=0.
REQ-037 Reset asserted during the 2nd MEM cycle of STORE -> next state IF, mem_write=0, retired=0.
REQ-038 CNT_W=4, 16 WB-type instructions -> retired=15, holding at 15.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared state encodings, RV32I major-opcode constants and opcode-class helpers
// for the multicycle control sequencer.
package micro_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF      = 3'd0,
        ST_ID      = 3'd1,
        ST_EX1     = 3'd2,
        ST_EX2     = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_e;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef struct packed {
        logic ir_write;
        logic pc_write;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic halted;
    } strobes_t;

    // Opcodes whose result is written back to the register file straight from EX2.
    function automatic logic is_wb_class(input logic [6:0] op);
        return (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_JAL) ||
               (op == OP_JALR)  || (op == OP_LUI)       || (op == OP_AUIPC);
    endfunction

    function automatic logic is_mem_class(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Control bus between the sequencer and the datapath: decode inputs in,
// state and strobes out.
interface micro_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             alu_bcond;
    logic             halt_cond;
    logic             mem_ready;
    logic [2:0]       current_state;
    logic             ir_write;
    logic             pc_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, alu_bcond, halt_cond, mem_ready,
        output current_state, ir_write, pc_write, mem_read, mem_write,
               reg_write, halted, retired
    );

    modport slave (
        output opcode, alu_bcond, halt_cond, mem_ready,
        input  current_state, ir_write, pc_write, mem_read, mem_write,
               reg_write, halted, retired
    );
endinterface

// File: rtl/micro_sequencer_mem_wait_timer.sv
// Fetch/memory-cycle completion timer: fixed latency count or ready handshake.
module mem_wait_timer #(
    parameter int MEM_LATENCY = 2,
    parameter int HANDSHAKE   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic ready_i,
    output logic done_o
);
    localparam int CW = 5;

    logic [CW-1:0] cnt_q, cnt_d;

    // start_i is high while a fetch/memory cycle is in progress; the count
    // falls back to zero whenever it is low or the cycle completes.
    always_comb begin
        if (HANDSHAKE != 0) begin
            done_o = start_i && ready_i;
        end else begin
            done_o = start_i && (cnt_q == CW'(MEM_LATENCY - 1));
        end
    end

    always_comb begin
        cnt_d = '0;
        if (start_i && !done_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Multicycle RV32I control sequencer: IF/ID/EX1/EX2/MEM/WB/HALT state machine
// with control strobes and a saturating retired-instruction counter.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int HANDSHAKE   = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    micro_sequencer_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_phase;
    logic             mem_done;
    strobes_t         strb;
    logic             is_load;
    logic             is_store;

    assign is_load   = (bus.opcode == OP_LOAD);
    assign is_store  = (bus.opcode == OP_STORE);
    assign mem_phase = (state_q == ST_IF) || (state_q == ST_MEM);

    mem_wait_timer #(
        .MEM_LATENCY (MEM_LATENCY),
        .HANDSHAKE   (HANDSHAKE)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (mem_phase),
        .ready_i (bus.mem_ready),
        .done_o  (mem_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF: begin
                if (mem_done) state_d = ST_ID;
            end
            ST_ID: begin
                if (bus.opcode == OP_ECALL) begin
                    state_d = bus.halt_cond ? ST_HALT : ST_IF;
                end else begin
                    state_d = ST_EX1;
                end
            end
            ST_EX1: begin
                if ((bus.opcode == OP_BRANCH) && !bus.alu_bcond) state_d = ST_IF;
                else                                             state_d = ST_EX2;
            end
            ST_EX2: begin
                if (bus.opcode == OP_BRANCH)         state_d = ST_IF;
                else if (is_wb_class(bus.opcode))    state_d = ST_WB;
                else if (is_mem_class(bus.opcode))   state_d = ST_MEM;
                else                                 state_d = ST_IF;
            end
            ST_MEM: begin
                if (mem_done) state_d = is_load ? ST_WB : ST_IF;
            end
            ST_WB:   state_d = ST_IF;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
    end

    always_comb begin
        strb = '0;
        case (state_q)
            ST_IF: begin
                strb.mem_read = 1'b1;
                strb.ir_write = mem_done;
            end
            ST_ID: begin
                strb.pc_write = (bus.opcode == OP_ECALL) && !bus.halt_cond;
            end
            ST_EX1: begin
                strb.pc_write = (bus.opcode == OP_BRANCH) && !bus.alu_bcond;
            end
            ST_EX2: begin
                strb.pc_write = !is_wb_class(bus.opcode) && !is_mem_class(bus.opcode);
            end
            ST_MEM: begin
                strb.mem_read  = is_load;
                strb.mem_write = is_store;
                strb.pc_write  = mem_done && !is_load;
            end
            ST_WB: begin
                strb.reg_write = 1'b1;
                strb.pc_write  = 1'b1;
            end
            ST_HALT: begin
                strb.halted = 1'b1;
            end
            default: strb = '0;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (strb.pc_write && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign bus.current_state = state_q;
    assign bus.ir_write      = strb.ir_write;
    assign bus.pc_write      = strb.pc_write;
    assign bus.mem_read      = strb.mem_read;
    assign bus.mem_write     = strb.mem_write;
    assign bus.reg_write     = strb.reg_write;
    assign bus.halted        = strb.halted;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: three sequencer configurations checked cycle by cycle
// against per-instruction expected traces built from the instruction rules.
module tb_micro_sequencer;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX1 = 3'd2, S_EX2 = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    localparam logic [6:0] O_LOAD = 7'h03, O_STORE = 7'h23, O_BRANCH = 7'h63,
                           O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37,
                           O_AUIPC = 7'h17, O_ARITH = 7'h33, O_ARITHI = 7'h13,
                           O_ECALL = 7'h73;

    // strobe vector order: {ir_write, pc_write, mem_read, mem_write, reg_write, halted}
    localparam logic [5:0] Z = 6'b000000, IRW = 6'b100000, PCW = 6'b010000,
                           MR = 6'b001000, MW = 6'b000100, RW = 6'b000010,
                           HLT = 6'b000001;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] strb;
        logic       rdy;
    } cyc_t;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [6:0] opcode;
    logic       bcond, hcond, rdy;

    always #5 clk = ~clk;

    micro_sequencer_if #(.CNT_W(32)) if0 ();
    micro_sequencer_if #(.CNT_W(32)) if1 ();
    micro_sequencer_if #(.CNT_W(4))  if2 ();

    assign if0.opcode = opcode; assign if0.alu_bcond = bcond;
    assign if0.halt_cond = hcond; assign if0.mem_ready = rdy;
    assign if1.opcode = opcode; assign if1.alu_bcond = bcond;
    assign if1.halt_cond = hcond; assign if1.mem_ready = rdy;
    assign if2.opcode = opcode; assign if2.alu_bcond = bcond;
    assign if2.halt_cond = hcond; assign if2.mem_ready = rdy;

    micro_sequencer #(.MEM_LATENCY(3), .HANDSHAKE(0), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(rst[0]), .bus(if0.master));
    micro_sequencer #(.MEM_LATENCY(2), .HANDSHAKE(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(rst[1]), .bus(if1.master));
    micro_sequencer #(.MEM_LATENCY(1), .HANDSHAKE(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset(rst[2]), .bus(if2.master));

    int          sel;
    logic [8:0]  obs;
    logic [31:0] obs_ret;

    always_comb begin
        case (sel)
            0: begin
                obs = {if0.current_state, if0.ir_write, if0.pc_write, if0.mem_read,
                       if0.mem_write, if0.reg_write, if0.halted};
                obs_ret = if0.retired;
            end
            1: begin
                obs = {if1.current_state, if1.ir_write, if1.pc_write, if1.mem_read,
                       if1.mem_write, if1.reg_write, if1.halted};
                obs_ret = if1.retired;
            end
            default: begin
                obs = {if2.current_state, if2.ir_write, if2.pc_write, if2.mem_read,
                       if2.mem_write, if2.reg_write, if2.halted};
                obs_ret = {28'd0, if2.retired};
            end
        endcase
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cur_lat, cur_hs;
    logic [31:0] cur_max;
    logic [31:0] exp_ret;
    cyc_t        q[$];

    task automatic push(input logic [2:0] st, input logic [5:0] s, input logic r);
        cyc_t e;
        e.st = st; e.strb = s; e.rdy = r;
        q.push_back(e);
    endtask

    // A fetch or memory phase: n cycles, the last one completing it.
    task automatic push_wait(input logic [2:0] st, input int n,
                             input logic [5:0] body, input logic [5:0] last);
        for (int i = 0; i < n; i++) begin
            logic r;
            if (cur_hs != 0) r = (i == n - 1);
            else             r = 1'($urandom);
            push(st, (i == n - 1) ? last : body, r);
        end
    endtask

    task automatic build_instr(input logic [6:0] op, input logic bc, input logic hc,
                               input int fw, input int mw);
        int nf, nm;
        nf = (cur_hs != 0) ? ((fw > 0) ? fw : int'($urandom_range(1, 4))) : cur_lat;
        nm = (cur_hs != 0) ? ((mw > 0) ? mw : int'($urandom_range(1, 4))) : cur_lat;
        push_wait(S_IF, nf, MR, MR | IRW);
        if (op == O_ECALL) begin
            push(S_ID, hc ? Z : PCW, 1'($urandom));
        end else begin
            push(S_ID, Z, 1'($urandom));
            if (op == O_BRANCH && !bc) begin
                push(S_EX1, PCW, 1'($urandom));
            end else begin
                push(S_EX1, Z, 1'($urandom));
                if (op == O_BRANCH) begin
                    push(S_EX2, PCW, 1'($urandom));
                end else if (op == O_ARITH || op == O_ARITHI || op == O_JAL ||
                             op == O_JALR || op == O_LUI || op == O_AUIPC) begin
                    push(S_EX2, Z, 1'($urandom));
                    push(S_WB, RW | PCW, 1'($urandom));
                end else if (op == O_LOAD) begin
                    push(S_EX2, Z, 1'($urandom));
                    push_wait(S_MEM, nm, MR, MR);
                    push(S_WB, RW | PCW, 1'($urandom));
                end else if (op == O_STORE) begin
                    push(S_EX2, Z, 1'($urandom));
                    push_wait(S_MEM, nm, MW, MW | PCW);
                end else begin
                    push(S_EX2, PCW, 1'($urandom));
                end
            end
        end
    endtask

    task automatic run_trace(input string name);
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            rdy = e.rdy;
            #1;
            checks++;
            if (obs !== {e.st, e.strb}) begin
                failures++;
                $display("FAIL %s cyc=%0d state+strobes got=%b expected=%b",
                         name, cyc, obs, {e.st, e.strb});
            end
            checks++;
            if (obs_ret !== exp_ret) begin
                failures++;
                $display("FAIL %s_retired cyc=%0d got=%0d expected=%0d",
                         name, cyc, obs_ret, exp_ret);
            end
            if (e.strb[4] && exp_ret != cur_max) exp_ret++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic bc,
                             input logic hc, input int fw, input int mw);
        opcode = op; bcond = bc; hcond = hc;
        build_instr(op, bc, hc, fw, mw);
        run_trace(name);
    endtask

    task automatic do_reset(input int s);
        sel     = s;
        cur_lat = (s == 0) ? 3 : (s == 1) ? 2 : 1;
        cur_hs  = (s == 1) ? 1 : 0;
        cur_max = (s == 2) ? 32'd15 : 32'hFFFF_FFFF;
        rst = 3'b111; opcode = O_ARITH; bcond = 1'b0; hcond = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[s]  = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_reset(input int s);
        logic [5:0] s_exp;
        do_reset(s);
        #1;
        s_exp = (cur_hs == 0 && cur_lat == 1) ? (MR | IRW) : MR;
        checks++;
        if (obs !== {S_IF, s_exp}) begin
            failures++;
            $display("FAIL reset_state dut=%0d got=%b expected=%b", s, obs, {S_IF, s_exp});
        end
        checks++;
        if (obs_ret !== 32'd0) begin
            failures++;
            $display("FAIL reset_retired dut=%0d got=%0d expected=0", s, obs_ret);
        end
    endtask

    task automatic test_arith();
        do_reset(0);
        run_instr("arith_lat3", O_ARITH, 1'b0, 1'b0, 0, 0);
        #1;
        checks++;
        if (obs_ret !== 32'd1 || obs[8:6] !== S_IF) begin
            failures++;
            $display("FAIL arith_after7 got_retired=%0d got_state=%0d expected retired=1 state=0",
                     obs_ret, obs[8:6]);
        end
    endtask

    task automatic test_branch();
        do_reset(0);
        run_instr("branch_nt", O_BRANCH, 1'b0, 1'b1, 0, 0);
        run_instr("branch_t", O_BRANCH, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_load_handshake();
        do_reset(1);
        run_instr("load_hs4", O_LOAD, 1'b0, 1'b0, 0, 4);
        run_instr("fetch_hs1", O_STORE, 1'b1, 1'b0, 1, 1);
        run_instr("load_hs1", O_LOAD, 1'b0, 1'b0, 3, 1);
    endtask

    task automatic test_halt();
        do_reset(0);
        run_instr("pre_halt", O_LUI, 1'b0, 1'b0, 0, 0);
        opcode = O_ECALL; hcond = 1'b1;
        build_instr(O_ECALL, 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 20; i++) push(S_HALT, HLT, 1'($urandom));
        run_trace("halt");
        rst[0] = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== {S_IF, MR} || obs_ret !== 32'd0) begin
            failures++;
            $display("FAIL halt_reset got=%b retired=%0d expected=%b retired=0",
                     obs, obs_ret, {S_IF, MR});
        end
        rst[0] = 1'b0; exp_ret = '0; hcond = 1'b0;
        run_instr("post_halt", O_ARITHI, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_mem();
        do_reset(0);
        run_instr("pre_store", O_ARITH, 1'b0, 1'b0, 0, 0);
        opcode = O_STORE; bcond = 1'b0; hcond = 1'b0;
        build_instr(O_STORE, 1'b0, 1'b0, 0, 0);
        while (q.size() > 7) void'(q.pop_back());
        run_trace("store_pre_reset");
        rst[0] = 1'b1;
        #1;
        checks++;
        if (obs !== {S_MEM, MW}) begin
            failures++;
            $display("FAIL store_mem2 got=%b expected=%b", obs, {S_MEM, MW});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== {S_IF, MR} || obs_ret !== 32'd0) begin
            failures++;
            $display("FAIL store_reset got=%b retired=%0d expected=%b retired=0",
                     obs, obs_ret, {S_IF, MR});
        end
        rst[0] = 1'b0; exp_ret = '0;
        run_instr("post_store_reset", O_JAL, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_saturate();
        logic [6:0] wb_ops [6];
        wb_ops = '{O_ARITH, O_ARITHI, O_JAL, O_JALR, O_LUI, O_AUIPC};
        do_reset(2);
        for (int i = 0; i < 16; i++)
            run_instr("sat", wb_ops[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), 0, 0);
        #1;
        checks++;
        if (obs_ret !== 32'd15) begin
            failures++;
            $display("FAIL sat_16 got=%0d expected=15", obs_ret);
        end
        for (int i = 0; i < 3; i++) run_instr("sat_hold", O_LUI, 1'b0, 1'b0, 0, 0);
        #1;
        checks++;
        if (obs_ret !== 32'd15) begin
            failures++;
            $display("FAIL sat_hold got=%0d expected=15", obs_ret);
        end
    endtask

    task automatic test_random(input int s);
        logic [6:0] ops [12];
        logic [6:0] op;
        ops = '{O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_LUI, O_AUIPC,
                O_ARITH, O_ARITHI, O_ECALL, 7'h7F, 7'h0F};
        do_reset(s);
        for (int i = 0; i < 40; i++) begin
            logic hc;
            if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 127));
            else                           op = ops[$urandom_range(0, 11)];
            hc = (op == O_ECALL) ? 1'b0 : 1'($urandom);
            run_instr("random", op, 1'($urandom), hc, 0, 0);
        end
    endtask

    initial begin
        sel = 0; rst = 3'b111; opcode = O_ARITH; bcond = 1'b0; hcond = 1'b0; rdy = 1'b0;
        exp_ret = '0; cur_lat = 3; cur_hs = 0; cur_max = 32'hFFFF_FFFF;
        test_reset(0);
        test_reset(1);
        test_reset(2);
        test_arith();
        test_branch();
        test_load_handshake();
        test_halt();
        test_reset_mid_mem();
        test_saturate();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
